// File: rtl/store_pkg.sv
// Shared execute-stage definitions: store/load opcodes, store FSM states,
// and the alignment rule used by the store stage.
package store_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        ST_NOP = 2'd0,
        SB     = 2'd1,
        SH     = 2'd2,
        SW     = 2'd3
    } store_op_e;

    typedef enum logic [2:0] {
        LD_NOP = 3'd0,
        LB     = 3'd1,
        LH     = 3'd2,
        LW     = 3'd3,
        LBU    = 3'd4,
        LHU    = 3'd5
    } load_op_e;

    typedef enum logic {
        STORE_RESET = 1'b0,
        WRITE_MEM   = 1'b1
    } store_state_e;

    // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never fault.
    function automatic logic store_is_misaligned(input store_op_e op, input logic [1:0] lsbs);
        logic mis;
        mis = 1'b0;
        case (op)
            SH:      mis = lsbs[0];
            SW:      mis = (lsbs != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/store_merge.sv
// Read-modify-write merge: inserts store data into the old RAM word at the
// byte/halfword lane selected by the captured address LSBs.
module store_merge
    import store_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] old_word,
    input  logic [XLEN-1:0] data,
    input  logic [1:0]      lsbs,
    input  store_op_e       op,
    output logic [XLEN-1:0] new_word
);

    // Lane replacement; anything not written keeps the old RAM contents.
    always_comb begin
        new_word = old_word;
        case (op)
            SB: begin
                case (lsbs)
                    2'd0: new_word[7:0]   = data[7:0];
                    2'd1: new_word[15:8]  = data[7:0];
                    2'd2: new_word[23:16] = data[7:0];
                    2'd3: new_word[31:24] = data[7:0];
                    default: new_word = old_word;
                endcase
            end
            SH: begin
                if (lsbs[1]) new_word[31:16] = data[15:0];
                else         new_word[15:0]  = data[15:0];
            end
            SW:      new_word = data;
            default: new_word = old_word;
        endcase
    end

endmodule

// File: rtl/store.sv
// Store-execute stage: SB/SH/SW to a word-addressed RAM without byte enables.
// Cycle 0 reads the old word and stalls the PC; cycle 1 writes the merged word.
module store
    import store_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [XLEN-1:0]   rs1_val,
    input  logic [XLEN-1:0]   rs2_val,
    input  logic [XLEN-1:0]   imm,
    input  logic [1:0]        store_control,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              stall_pc,
    output logic              stall_other_exec,
    output logic              store_misaligned,
    output logic              mem_rw_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata
);

    store_state_e      state, state_next;
    store_op_e         op_in, op_q;
    logic [1:0]        lsbs_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [XLEN-1:0]   data_q;
    logic [XLEN-1:0]   ea;
    logic [XLEN-1:0]   merged;
    logic              misaligned;
    logic              accept;
    logic              unused_ea_hi;

    assign op_in        = store_op_e'(store_control);
    assign ea           = rs1_val + imm;
    assign misaligned   = store_is_misaligned(op_in, ea[1:0]);
    // Effective-address bits above the RAM window are dropped (4 KiB wrap).
    assign unused_ea_hi = ^ea[XLEN-1:ADDR_W+2];

    store_merge #(.XLEN(XLEN)) u_merge (
        .old_word (mem_rdata),
        .data     (data_q),
        .lsbs     (lsbs_q),
        .op       (op_q),
        .new_word (merged)
    );

    // State register and operand capture on accept; reset clears both.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= STORE_RESET;
            op_q    <= ST_NOP;
            lsbs_q  <= '0;
            waddr_q <= '0;
            data_q  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q    <= op_in;
                lsbs_q  <= ea[1:0];
                waddr_q <= ea[ADDR_W+1:2];
                data_q  <= rs2_val;
            end
        end
    end

    // Next state and memory/stall outputs.
    always_comb begin
        state_next       = state;
        accept           = 1'b0;
        stall_pc         = 1'b0;
        stall_other_exec = 1'b0;
        store_misaligned = 1'b0;
        mem_rw_mode      = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        case (state)
            STORE_RESET: begin
                if (!i_rst && op_in != ST_NOP) begin
                    if (misaligned) begin
                        store_misaligned = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        mem_addr   = ea[ADDR_W+1:2];
                        stall_pc   = 1'b1;
                        state_next = WRITE_MEM;
                    end
                end
            end
            WRITE_MEM: begin
                // Write gated by reset so an abort never commits a partial store.
                mem_rw_mode      = !i_rst;
                mem_addr         = waddr_q;
                mem_wdata        = merged;
                stall_other_exec = 1'b1;
                state_next       = STORE_RESET;
            end
            default: state_next = STORE_RESET;
        endcase
    end

endmodule

// File: tb/tb_store.sv
// Self-checking bench for the store stage: directed vector table, reset and
// back-to-back sequences, and randomized stores against a byte-array model.
module tb_store;
    import store_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rs1, rs2, imm, mem_rdata;
    logic [1:0]  sc;
    logic        stall_pc, stall_other_exec, store_misaligned, mem_rw_mode;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;

    int unsigned checks = 0;
    int unsigned errors = 0;

    bit [31:0] ram [0:1023];
    bit [7:0]  ref_mem [0:4095];

    logic        pre_we;
    logic [9:0]  pre_addr;
    logic [31:0] pre_data;

    store #(.XLEN(32), .ADDR_W(10)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .rs1_val          (rs1),
        .rs2_val          (rs2),
        .imm              (imm),
        .store_control    (sc),
        .mem_rdata        (mem_rdata),
        .stall_pc         (stall_pc),
        .stall_other_exec (stall_other_exec),
        .store_misaligned (store_misaligned),
        .mem_rw_mode      (mem_rw_mode),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM with registered read data; bench preload port has priority.
    always @(posedge clk) begin
        if (pre_we)           ram[pre_addr] <= pre_data;
        else if (mem_rw_mode) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [9:0] w);
        return {ref_mem[{w, 2'd3}], ref_mem[{w, 2'd2}], ref_mem[{w, 2'd1}], ref_mem[{w, 2'd0}]};
    endfunction

    task automatic model_apply(input store_op_e op, input logic [31:0] ea, input logic [31:0] d);
        logic [11:0] b;
        b = ea[11:0];
        case (op)
            SB: ref_mem[b] = d[7:0];
            SH: begin
                ref_mem[b]         = d[7:0];
                ref_mem[b + 12'd1] = d[15:8];
            end
            SW: begin
                ref_mem[{b[11:2], 2'd0}] = d[7:0];
                ref_mem[{b[11:2], 2'd1}] = d[15:8];
                ref_mem[{b[11:2], 2'd2}] = d[23:16];
                ref_mem[{b[11:2], 2'd3}] = d[31:24];
            end
            default: ;
        endcase
    endtask

    // Entered and left just after a rising edge.
    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
        ref_mem[{a, 2'd0}] = d[7:0];
        ref_mem[{a, 2'd1}] = d[15:8];
        ref_mem[{a, 2'd2}] = d[23:16];
        ref_mem[{a, 2'd3}] = d[31:24];
    endtask

    task automatic idle();
        sc = ST_NOP;
        @(negedge clk);
        chk("idle_addr", 32'(mem_addr), 32'd0);
        chk("idle_wdata", mem_wdata, 32'd0);
        chk("idle_flags", 32'({stall_pc, stall_other_exec, mem_rw_mode, store_misaligned}), 32'd0);
        @(posedge clk); #1;
    endtask

    // Applies one store; control is held through the write cycle and left
    // asserted on return so a following call forms a back-to-back pair.
    task automatic run_store(input store_op_e op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] d);
        logic [31:0] ea, ew;
        logic [9:0]  wa;
        bit          mis;
        ea  = a + b;
        wa  = ea[11:2];
        mis = (op == SH && ea[0]) || (op == SW && ea[1:0] != 2'b00);
        rs1 = a; imm = b; rs2 = d; sc = op;
        @(negedge clk);
        if (mis) begin
            chk("mis_pulse", 32'(store_misaligned), 32'd1);
            chk("mis_rw", 32'(mem_rw_mode), 32'd0);
            chk("mis_stall_pc", 32'(stall_pc), 32'd0);
            ew = model_word(wa);
            @(posedge clk); #1;
            sc = ST_NOP;
            @(negedge clk);
            chk("mis_after", 32'({stall_pc, stall_other_exec, mem_rw_mode, store_misaligned}), 32'd0);
            chk("mis_ram", ram[wa], ew);
            @(posedge clk); #1;
        end else begin
            chk("rd_addr", 32'(mem_addr), 32'(wa));
            chk("rd_rw", 32'(mem_rw_mode), 32'd0);
            chk("rd_stall_pc", 32'(stall_pc), 32'd1);
            chk("rd_stall_other", 32'(stall_other_exec), 32'd0);
            model_apply(op, ea, d);
            ew = model_word(wa);
            @(posedge clk); #1;
            @(negedge clk);
            chk("wr_rw", 32'(mem_rw_mode), 32'd1);
            chk("wr_addr", 32'(mem_addr), 32'(wa));
            chk("wr_data", mem_wdata, ew);
            chk("wr_stall_other", 32'(stall_other_exec), 32'd1);
            chk("wr_stall_pc", 32'(stall_pc), 32'd0);
            @(posedge clk); #1;
            chk("ram_word", ram[wa], ew);
        end
    endtask

    typedef struct {
        store_op_e   op;
        logic [31:0] rs1;
        logic [31:0] imm;
        logic [31:0] rs2;
        logic [9:0]  waddr;
        logic [31:0] pre_word;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{SW, 32'h0000_0100, 32'd4,          32'hDEAD_BEEF, 10'h041, 32'h0000_0000, 32'hDEAD_BEEF};
        vecs[1]  = '{SB, 32'h0000_0100, 32'd2,          32'h0000_00AB, 10'h040, 32'h1122_3344, 32'h11AB_3344};
        vecs[2]  = '{SH, 32'h0000_0100, 32'd2,          32'h0000_BEEF, 10'h040, 32'h1122_3344, 32'hBEEF_3344};
        vecs[3]  = '{SH, 32'h0000_0100, 32'd0,          32'h0000_BEEF, 10'h040, 32'h1122_3344, 32'h1122_BEEF};
        vecs[4]  = '{SW, 32'h0000_0100, 32'd1,          32'hCAFE_F00D, 10'h040, 32'h1122_3344, 32'h1122_3344};
        vecs[5]  = '{SH, 32'h0000_0100, 32'd3,          32'h0000_BEEF, 10'h040, 32'h1122_3344, 32'h1122_3344};
        vecs[6]  = '{SW, 32'hFFFF_FFFC, 32'd8,          32'h0102_0304, 10'h001, 32'h0000_0000, 32'h0102_0304};
        vecs[7]  = '{SW, 32'h0000_1000, 32'd0,          32'hA5A5_A5A5, 10'h000, 32'h0000_0000, 32'hA5A5_A5A5};
        vecs[8]  = '{SB, 32'h0000_0FFF, 32'd0,          32'h0000_0077, 10'h3FF, 32'hAABB_CCDD, 32'h77BB_CCDD};
        vecs[9]  = '{SB, 32'h0000_0400, 32'h0000_000C,  32'h0000_01FF, 10'h103, 32'h1234_5678, 32'h1234_56FF};
        vecs[10] = '{SH, 32'h0000_0210, 32'hFFFF_FFF2,  32'h1234_5566, 10'h080, 32'hCCCC_CCCC, 32'h5566_CCCC};

        rst = 1'b1; sc = ST_NOP; rs1 = '0; rs2 = '0; imm = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_addr", 32'(mem_addr), 32'd0);
        chk("reset_wdata", mem_wdata, 32'd0);
        chk("reset_flags", 32'({stall_pc, stall_other_exec, mem_rw_mode, store_misaligned}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();

        foreach (vecs[i]) begin
            preload(vecs[i].waddr, vecs[i].pre_word);
            run_store(vecs[i].op, vecs[i].rs1, vecs[i].imm, vecs[i].rs2);
            idle();
            chk($sformatf("vec%0d_word", i), ram[vecs[i].waddr], vecs[i].exp_word);
        end

        // Back-to-back byte stores into adjacent lanes of one word.
        preload(10'h0C0, 32'h0000_0000);
        run_store(SB, 32'h0000_0300, 32'd0, 32'h0000_0011);
        run_store(SB, 32'h0000_0300, 32'd1, 32'h0000_0022);
        idle();
        chk("b2b_word", ram[10'h0C0], 32'h0000_2211);

        // Reset during the write cycle must abort the write.
        preload(10'h050, 32'h1234_5678);
        rs1 = 32'h0000_0140; imm = '0; rs2 = 32'hCAFE_F00D; sc = SW;
        @(negedge clk);
        chk("rst_rd_stall_pc", 32'(stall_pc), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wr_rw", 32'(mem_rw_mode), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; sc = ST_NOP;
        @(negedge clk);
        chk("rst_after_addr", 32'(mem_addr), 32'd0);
        chk("rst_after_wdata", mem_wdata, 32'd0);
        chk("rst_after_flags", 32'({stall_pc, stall_other_exec, mem_rw_mode, store_misaligned}), 32'd0);
        chk("rst_ram", ram[10'h050], 32'h1234_5678);
        @(posedge clk); #1;
        idle();

        // Randomized stores concentrated in a small window to force overlap.
        for (int n = 0; n < 60; n++) begin
            store_op_e   op;
            logic [31:0] a, b, d;
            op = store_op_e'($urandom_range(1, 3));
            a  = 32'h0000_1000 * $urandom + 32'($urandom_range(0, 255));
            b  = 32'($urandom_range(0, 63));
            d  = $urandom;
            run_store(op, a, b, d);
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
        for (int w = 0; w < 96; w++) begin
            chk($sformatf("sweep_%0d", w), ram[w], model_word(10'(w)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
